hw_stack: RTL

Parametrised hardware stack that replaces the fixed 8-bit, down-counting stack-pointer counter in the CPU datapath. It owns both the pointer and the storage, and supports push, pop and replace-top operations. It flags overflow and underflow with sticky error bits, and drives its top-of-stack onto the shared tri-state data bus when enabled. Control sequencing comes from the control unit; the block sits on the CPU data bus next to the program counter and register file.

---
 rtl/hw_stack_if.sv | 31 +++
 rtl/hw_stack.sv | 89 ++++++++
 2 files changed

// File: rtl/hw_stack_if.sv
// Control-unit <-> hardware stack signal bundle.
// The tri-state bus output is kept out of this bundle. It joins the shared
// CPU data-bus net as a plain port.
interface hw_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             oe;
  logic             clr_err;
  logic [WIDTH-1:0] top;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, din, oe, clr_err,
    input  top, level, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, din, oe, clr_err,
    output top, level, full, empty, overflow, underflow
  );
endinterface

// File: rtl/hw_stack.sv
// Parametrised downward-growing hardware stack with sticky error flags and
// tri-state top-of-stack bus drive. The entry at level k lives at mem[DEPTH-k].
module hw_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  hw_stack_if.slave        s,
  output logic [WIDTH-1:0] bus_out
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] top_q;
  logic             ovf_q, unf_q;

  logic             full, empty;
  logic             do_push, do_repl, do_pop, rej_push, rej_pop;
  logic [AW-1:0]    wr_idx, top_idx, below_idx;
  logic [WIDTH-1:0] below;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // Decode {push,pop} into exactly one action. Push+pop on an empty stack
  // degrades to a plain push.
  always_comb begin
    do_push  = s.push & (~s.pop | empty) & ~full;
    do_repl  = s.push &  s.pop & ~empty;
    do_pop   = s.pop  & ~s.push & ~empty;
    rej_push = s.push & ~s.pop & full;
    rej_pop  = s.pop  & ~s.push & empty;
  end

  // Storage addresses. These are only used when the stack state makes them
  // in range, so truncation of the out-of-range cases is harmless.
  always_comb begin
    wr_idx    = AW'(DEPTH - 1 - int'(level_q));
    top_idx   = AW'(DEPTH - int'(level_q));
    below_idx = AW'(DEPTH + 1 - int'(level_q));
    below     = (level_q > LW'(1)) ? mem[below_idx] : '0;
  end

  // Storage writes. Contents are never cleared, and reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_push)      mem[wr_idx]  <= s.din;
      else if (do_repl) mem[top_idx] <= s.din;
    end
  end

  // Pointer, registered top and sticky flags. When a rejection and a clear
  // happen in the same cycle, the rejection sets the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (do_push) begin
        level_q <= level_q + LW'(1);
        top_q   <= s.din;
      end else if (do_repl) begin
        top_q   <= s.din;
      end else if (do_pop) begin
        level_q <= level_q - LW'(1);
        top_q   <= below;
      end
      if (rej_push)       ovf_q <= 1'b1;
      else if (s.clr_err) ovf_q <= 1'b0;
      if (rej_pop)        unf_q <= 1'b1;
      else if (s.clr_err) unf_q <= 1'b0;
    end
  end

  assign s.top       = top_q;
  assign s.level     = level_q;
  assign s.full      = full;
  assign s.empty     = empty;
  assign s.overflow  = ovf_q;
  assign s.underflow = unf_q;

  // The bus shows the pre-edge top, so a pop with oe=1 puts the old top on the bus.
  assign bus_out = s.oe ? top_q : {WIDTH{1'bz}};
endmodule
